output_scan_ctrl: RTL and testbench
===================================

Name: output_scan_ctrl

Overview:
- Controller that drives the 8-bit output register value onto a single multiplexed 3-digit seven-segment display.
- On a load strobe it captures a byte and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes hundreds/tens/units onto one shared segment bus with one-hot digit enables.
- Sits between the output register and the board display pins. It replaces the three parallel combinational decoders with one shared decoder.

Parameters:
- REFRESH_DIV, 1000, clk cycles each digit stays enabled before the scan advances; legal range 2..65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- load  input  1  single-cycle strobe; capture data_in for display.
- data_in  input  8  unsigned value to display (0..255).
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when a new BCD value is committed.
- bcd  output  12  committed BCD value: [11:8] hundreds, [7:4] tens, [3:0] units.
- seg  output  7  segment drive, active high; seg[0]=a … seg[6]=g.
- an  output  3  one-hot digit enable, active high; an[0]=units, an[1]=tens, an[2]=hundreds.

Behaviour:
- Reset (rst=0, async) forces:
  - state=IDLE, busy=0, done=0, bcd=12'h000, pending flag=0;
  - refresh counter=0, an=3'b001, seg=7'h3F.
- FSM states: IDLE, CONV.
  - IDLE: load=1 captures data_in into the shift register, clears the BCD scratch, sets iteration count=0, goes to CONV.
  - CONV: each cycle, add 3 to every scratch nibble >=5, then shift {scratch,shift} left by 1 and increment count.
  - After the 8th CONV cycle: bcd<=scratch result and done=1 for one cycle, on the same edge.
  - Next state after the 8th CONV cycle: CONV if the pending flag is set, otherwise IDLE.
- Latency: load sampled at edge k → busy=1 from edge k; bcd updated and done high from edge k+8 for exactly one cycle.
- busy = (state==CONV).
- Load while busy:
  - data_in goes into a one-deep pending buffer and the pending flag is set.
  - A later load while the flag is still set overwrites the buffer (latest wins).
  - On completion, the pending value starts a new conversion immediately with no IDLE cycle, and the flag clears.
  - A load on the completion cycle itself is treated as pending and restarts.
- bcd changes only on done edges, so the display never shows a partial conversion.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - On wrap, an rotates 001→010→100→001.
  - seg is registered and updates on the same edge as an, using the decode of the digit selected by the new an.
  - When bcd changes, seg also refreshes on the following edge for the currently enabled digit.
- Decode, digits 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F. Nibble values >9 cannot occur; they decode to 7'h00.
- Reset mid-conversion:
  - the conversion is abandoned and bcd returns to 000;
  - the pending value is discarded.

Optional Feature:
- Macro OUTPUT_SCAN_BLANK_EN.
- Defined: leading-zero blanking.
  - The hundreds digit drives seg=7'h00 when bcd[11:8]==0.
  - The tens digit drives seg=7'h00 when bcd[11:4]==0.
  - The units digit is never blanked.
- Undefined: all three digits are always decoded, e.g. 7 shows "007".
- No effect on bcd, done, busy or an.

Decomposition:
- Shared package output_pkg:
  - state enum (IDLE, CONV);
  - SEG_0..SEG_9 and SEG_BLANK constants;
  - BCD_W=12, DATA_W=8;
  - CONV_CYCLES=8.
- One sub-module, bin2bcd_seq:
  - owns the shift/add-3 datapath, iteration counter and start/done handshake;
  - the parent keeps the pending buffer, scan counter and segment decode.

Test Plan:
- Reset, then load=1 with data_in=8'd255 → busy from next edge; 8 cycles later bcd=12'h255 and done=1 for one cycle; with REFRESH_DIV=4 the seg sequence is units 6D, tens 6D, hundreds 5B, each held 4 cycles.
- Load 8'd42, then load 8'd100 three cycles later, then 8'd7 two cycles after that → done#1 gives bcd=042; the second conversion starts with no gap; done#2 gives bcd=007 (100 overwritten).
- Load 8'd199, assert rst low on the 4th CONV cycle → bcd=000, busy=0, an=001, seg=3F immediately; after release, no done pulse.
- data_in=0 and 9, 10, 99, 100 (one load each, waiting for done) → bcd=000, 009, 010, 099, 100.
- With OUTPUT_SCAN_BLANK_EN: load 8'd7 → hundreds and tens seg=00, units seg=07; load 8'd105 → tens shows 3F (not blanked).
- Back-to-back loads on the exact completion cycle → the restart occurs, busy stays high continuously, and exactly one done pulse occurs per conversion.

Source files
------------

// File: rtl/output_pkg.sv
// Shared types, segment constants and helpers for the output_scan_ctrl display path.
package output_pkg;

  localparam int BCD_W       = 12;
  localparam int DATA_W      = 8;
  localparam int CONV_CYCLES = 8;
  localparam int CNT_W       = $clog2(CONV_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: a nibble >= 5 would overflow past 9 after the next shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter: one bit per cycle, commits the
// result and pulses done on the edge that ends the last iteration.
module bin2bcd_seq
  import output_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              ready,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]    scratch_q, scratch_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                done_q, done_d;
  logic                last;
  logic [BCD_W-1:0]    adj;
  logic [BCD_W-1:0]    shifted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CONV;
      CONV:    if (last)  state_d = start ? CONV : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last  = (state_q == CONV) && (cnt_q == CNT_W'(CONV_CYCLES - 1));
    busy  = (state_q == CONV);
    ready = (state_q == IDLE) || last;
  end

  assign adj     = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
  assign shifted = {adj[BCD_W-2:0], shift_q[DATA_W-1]};

  always_comb begin
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    if (state_q == CONV) begin
      scratch_d = shifted;
      shift_d   = {shift_q[DATA_W-2:0], 1'b0};
      cnt_d     = cnt_q + 1'b1;
    end
    if (last) begin
      bcd_d  = shifted;
      done_d = 1'b1;
    end
    // A restart on the completion cycle overrides the iteration update above.
    if (ready && start) begin
      shift_d   = din;
      scratch_d = '0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/output_scan_ctrl.sv
// Captures a byte, converts it to BCD and scans it onto a multiplexed 3-digit display.
// Optional leading-zero blanking is enabled by defining OUTPUT_SCAN_BLANK_EN.
module output_scan_ctrl
  import output_pkg::*;
#(
  parameter int REFRESH_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd,
  output logic [6:0]        seg,
  output logic [2:0]        an
);

  localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);

  logic              conv_ready;
  logic              conv_start;
  logic [DATA_W-1:0] conv_din;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] pend_buf_q, pend_buf_d;
  logic [15:0]       refresh_q, refresh_d;
  logic [2:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        digit;
  logic              blank;

  // A load arriving together with a pending value wins: latest data is displayed.
  assign conv_start = conv_ready && (load || pend_q);
  assign conv_din   = load ? data_in : pend_buf_q;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .din   (conv_din),
    .busy  (busy),
    .ready (conv_ready),
    .done  (done),
    .bcd   (bcd)
  );

  always_comb begin
    pend_d     = pend_q;
    pend_buf_d = pend_buf_q;
    if (conv_start) begin
      pend_d = 1'b0;
    end else if (load) begin
      pend_d     = 1'b1;
      pend_buf_d = data_in;
    end
  end

  always_comb begin
    refresh_d = refresh_q + 16'd1;
    an_d      = an_q;
    if (refresh_q == REFRESH_LAST) begin
      refresh_d = '0;
      an_d      = {an_q[1:0], an_q[2]};
    end
  end

  // Decode against the next digit enable so seg and an switch on the same edge.
  always_comb begin
    digit = bcd[3:0];
    blank = 1'b0;
    case (an_d)
      3'b010:  digit = bcd[7:4];
      3'b100:  digit = bcd[11:8];
      default: ;
    endcase
`ifdef OUTPUT_SCAN_BLANK_EN
    blank = ((an_d == 3'b100) && (bcd[11:8] == 4'd0)) ||
            ((an_d == 3'b010) && (bcd[11:4] == 8'd0));
`else
    blank = 1'b0;
`endif
    seg_d = blank ? SEG_BLANK : seg_decode(digit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q     <= 1'b0;
      pend_buf_q <= '0;
      refresh_q  <= '0;
      an_q       <= 3'b001;
      seg_q      <= SEG_0;
    end else begin
      pend_q     <= pend_d;
      pend_buf_q <= pend_buf_d;
      refresh_q  <= refresh_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_output_scan_ctrl.sv
// Self-checking bench for output_scan_ctrl: table-driven conversions, a done-driven
// scoreboard, and hand sequences for pending loads, restarts, scan and reset.
module tb_output_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [7:0]  data_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [2:0]  an;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [7:0]  din;
    logic [11:0] exp_bcd;
  } vec_t;
  vec_t vecs[6];

  output_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd),
    .seg     (seg),
    .an      (an)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input logic [7:0] d);
    int v;
    v = int'(d);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [11:0] b, input logic [2:0] a);
    logic [6:0] s;
    s = dec(b[3:0]);
    if (a == 3'b010) begin
      s = dec(b[7:4]);
`ifdef OUTPUT_SCAN_BLANK_EN
      if (b[11:4] == 8'd0) s = 7'h00;
`endif
    end else if (a == 3'b100) begin
      s = dec(b[11:8]);
`ifdef OUTPUT_SCAN_BLANK_EN
      if (b[11:8] == 4'd0) s = 7'h00;
`endif
    end
    return s;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got bcd=%h, expected no done", bcd);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        $display("done bcd=%h expected=%h", bcd, e);
        check("done_bcd", 32'(bcd), 32'(e));
      end
    end
  end

  task automatic do_load(input logic [7:0] d);
    exp_q.push_back(to_bcd(d));
    $display("load data_in=%0d", d);
    load    = 1'b1;
    data_in = d;
    tick();
    load    = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int guard;
    guard = 0;
    while (n_done < target && guard < 30) begin
      tick();
      guard++;
    end
    check("done_timeout", 32'(n_done >= target), 32'd1);
  endtask

  // Align to an 100->001 wrap, then walk one full rotation (REFRESH_DIV=4).
  task automatic check_scan(input logic [11:0] b);
    logic [2:0] prev;
    logic [2:0] ea;
    int guard;
    prev  = an;
    tick();
    guard = 1;
    while (!(prev == 3'b100 && an == 3'b001) && guard < 20) begin
      prev = an;
      tick();
      guard++;
    end
    check("scan_align_timeout", 32'(guard < 20), 32'd1);
    for (int j = 0; j < 12; j++) begin
      ea = 3'b001 << (j / 4);
      check("scan_an", 32'(an), 32'(ea));
      check("scan_seg", 32'(seg), 32'(exp_seg(b, ea)));
      $display("scan bcd=%h an=%b seg=%h", b, an, seg);
      tick();
    end
  endtask

  initial begin
    int base;
    vecs[0] = '{8'd0,   12'h000};
    vecs[1] = '{8'd9,   12'h009};
    vecs[2] = '{8'd10,  12'h010};
    vecs[3] = '{8'd99,  12'h099};
    vecs[4] = '{8'd100, 12'h100};
    vecs[5] = '{8'd255, 12'h255};

    rst = 1'b0; load = 1'b0; data_in = 8'd0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd",  32'(bcd),  32'h000);
    check("rst_an",   32'(an),   32'b001);
    check("rst_seg",  32'(seg),  32'h3F);
    rst = 1'b1;
    tick();

    // 255: latency and one-cycle done, then the scan pattern 6D/6D/5B
    do_load(8'd255);
    check("lat_busy_k", 32'(busy), 32'd1);
    check("lat_done_k", 32'(done), 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("lat_done_early", 32'(done), 32'd0);
      check("lat_busy_run", 32'(busy), 32'd1);
    end
    tick();
    check("lat_done_k8", 32'(done), 32'd1);
    check("lat_bcd_k8",  32'(bcd),  32'h255);
    check("lat_busy_k8", 32'(busy), 32'd0);
    tick();
    check("lat_done_k9", 32'(done), 32'd0);
    check_scan(12'h255);

    // table-driven single conversions
    for (int v = 0; v < 6; v++) begin
      base = n_done;
      exp_q.push_back(vecs[v].exp_bcd);
      $display("load data_in=%0d", vecs[v].din);
      load = 1'b1; data_in = vecs[v].din;
      tick();
      load = 1'b0;
      wait_done(base + 1);
      tick();
      check("vec_bcd_hold", 32'(bcd), 32'(vecs[v].exp_bcd));
    end

    // loads while busy: 100 is overwritten by 7, second conversion starts with no gap
    base = n_done;
    do_load(8'd42);
    for (int i = 0; i < 16; i++) begin
      check("pend_busy", 32'(busy), 32'd1);
      if (i == 2) begin
        load = 1'b1; data_in = 8'd100;
        exp_q.push_back(to_bcd(8'd100));
      end else if (i == 4) begin
        load = 1'b1; data_in = 8'd7;
        exp_q[exp_q.size() - 1] = to_bcd(8'd7);
      end else begin
        load = 1'b0;
      end
      tick();
    end
    load = 1'b0;
    check("pend_idle", 32'(busy), 32'd0);
    tick();
    check("pend_done_count", 32'(n_done - base), 32'd2);
    check("pend_bcd", 32'(bcd), 32'h007);

    // loads landing exactly on the completion cycle
    base = n_done;
    do_load(8'd5);
    for (int i = 0; i < 24; i++) begin
      check("b2b_busy", 32'(busy), 32'd1);
      if (i == 7) begin
        load = 1'b1; data_in = 8'd50; exp_q.push_back(to_bcd(8'd50));
      end else if (i == 15) begin
        load = 1'b1; data_in = 8'd250; exp_q.push_back(to_bcd(8'd250));
      end else begin
        load = 1'b0;
      end
      tick();
    end
    load = 1'b0;
    check("b2b_idle", 32'(busy), 32'd0);
    tick();
    check("b2b_done_count", 32'(n_done - base), 32'd3);

    // scan patterns for small values (blanking-dependent)
    base = n_done;
    do_load(8'd7);
    wait_done(base + 1);
    check_scan(to_bcd(8'd7));
    base = n_done;
    do_load(8'd105);
    wait_done(base + 1);
    check_scan(to_bcd(8'd105));

    // reset during the 4th conversion cycle
    do_load(8'd199);
    repeat (3) tick();
    rst = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("mid_rst_bcd",  32'(bcd),  32'h000);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_an",   32'(an),   32'b001);
    check("mid_rst_seg",  32'(seg),  32'h3F);
    repeat (2) tick();
    rst  = 1'b1;
    base = n_done;
    repeat (15) tick();
    check("post_rst_no_done", 32'(n_done - base), 32'd0);
    check("post_rst_bcd",     32'(bcd),           32'h000);
    check("post_rst_busy",    32'(busy),          32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
